// File: rtl/gf571_reduce.sv
// Reduces a 1141-bit carry-less product modulo f(x) = x^571 + x^10 + x^5 + x^2 + 1 in two folds.
// Optional GF571_RED_SQR_EN adds a sqr input that squares c[570:0] by bit-spreading before reduction.
module gf571_reduce (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1140:0]   c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [570:0]    r,
  output logic            busy
`ifdef GF571_RED_SQR_EN
  ,
  input  logic            sqr
`endif
);

  typedef enum logic [1:0] {StIdle, StFold1, StFold2, StDone} state_e;

  state_e        state_q, state_d;
  logic [1140:0] c_q, c_d;
  logic [579:0]  t_q, t_d;
  logic [570:0]  r_q, r_d;

  logic [1140:0] c_load;
  logic [579:0]  h1_ext;
  logic [579:0]  t_fold;
  logic [570:0]  h2_ext;
  logic [570:0]  r_fold;

`ifdef GF571_RED_SQR_EN
  // Squaring in GF(2) is a bit-spread: coefficient i moves to 2i, odd bits stay clear.
  always_comb begin
    c_load = c;
    if (sqr) begin
      c_load = '0;
      for (int i = 0; i < 571; i++) begin
        c_load[2*i] = c[i];
      end
    end
  end
`else
  assign c_load = c;
`endif

  // x^571 == x^10 + x^5 + x^2 + 1, so each high part folds back as four shifted copies.
  always_comb begin
    h1_ext = {10'b0, c_q[1140:571]};
    t_fold = {9'b0, c_q[570:0]} ^ h1_ext ^ (h1_ext << 2) ^ (h1_ext << 5) ^ (h1_ext << 10);
    h2_ext = {562'b0, t_q[579:571]};
    r_fold = t_q[570:0] ^ h2_ext ^ (h2_ext << 2) ^ (h2_ext << 5) ^ (h2_ext << 10);
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    t_d     = t_q;
    r_d     = r_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          c_d     = c_load;
          state_d = StFold1;
        end
      end
      StFold1: begin
        t_d     = t_fold;
        state_d = StFold2;
      end
      StFold2: begin
        r_d     = r_fold;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      t_q     <= t_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign r         = r_q;

endmodule

// File: tb/tb_gf571_reduce.sv
// Scoreboard bench for gf571_reduce: expected residues are queued at acceptance and checked on output.
module tb_gf571_reduce;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1140:0] c;
  logic          out_valid;
  logic          out_ready;
  logic [570:0]  r;
  logic          busy;
`ifdef GF571_RED_SQR_EN
  logic          sqr;
`endif

  gf571_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy)
`ifdef GF571_RED_SQR_EN
    ,
    .sqr       (sqr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [570:0] exp_q[$];
  int           acc_q[$];
  logic         ov_prev   = 1'b0;
  logic         stream_on = 1'b0;
  logic         have_last = 1'b0;
  int           last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [570:0] got, input logic [570:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Schoolbook long division by f, top coefficient first.
  function automatic logic [570:0] mod_f(input logic [1140:0] x);
    logic [1140:0] a;
    logic [1140:0] f_poly;
    a = x;
    f_poly = '0;
    f_poly[571] = 1'b1;
    f_poly[10]  = 1'b1;
    f_poly[5]   = 1'b1;
    f_poly[2]   = 1'b1;
    f_poly[0]   = 1'b1;
    for (int i = 1140; i >= 571; i--) begin
      if (a[i]) a = a ^ (f_poly << (i - 571));
    end
    return a[570:0];
  endfunction

  function automatic logic [1140:0] rand_wide();
    logic [1140:0] v;
    v = '0;
    for (int k = 0; k < 36; k++) v = {v[1108:0], 32'($urandom())};
    return v;
  endfunction

  // Inputs are driven just after the rising edge; outputs sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && !ov_prev) begin
          if (acc_q.size() == 0) begin
            check_eq("orphan_valid", 571'(acc_q.size()), 571'd1);
          end else begin
            check_eq("latency", 571'(cyc - acc_q.pop_front()), 571'd3);
          end
          if (stream_on) begin
            if (have_last) check_eq("throughput", 571'(cyc - last_rise), 571'd4);
            have_last = 1'b1;
            last_rise = cyc;
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("orphan_result", 571'(exp_q.size()), 571'd1);
          end else begin
            check_eq("result", r, exp_q.pop_front());
          end
        end
      end
      ov_prev = rst ? 1'b0 : out_valid;
    end
  end

  task automatic send(input logic [1140:0] v, input logic [570:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 571'(in_ready), 571'd1);
    in_valid = 1'b1;
    c        = v;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c        = rand_wide();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", 571'(exp_q.size()), 571'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("valid_rise", 571'(out_valid), 571'd1);
  endtask

  initial begin
    logic [1140:0] v;
    logic [570:0]  e;

    rst       = 1'b1;
    in_valid  = 1'b0;
    c         = '0;
    out_ready = 1'b1;
`ifdef GF571_RED_SQR_EN
    sqr       = 1'b0;
`endif
    #2;
    check_eq("rst_r", r, '0);
    check_eq("rst_out_valid", 571'(out_valid), 571'd0);
    check_eq("rst_busy", 571'(busy), 571'd0);
    check_eq("rst_in_ready", 571'(in_ready), 571'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // x^571 accepted on the very first edge after reset.
    v = '0;
    v[571] = 1'b1;
    send(v, 571'h425);
    wait_drain();

    // x^1140 needs the second fold.
    v = '0;
    v[1140] = 1'b1;
    e = '0;
    e[569] = 1'b1;
    e[18]  = 1'b1;
    e[3]   = 1'b1;
    e[2]   = 1'b1;
    e[0]   = 1'b1;
    send(v, e);
    wait_drain();

    // Already-reduced operand, with consumer back-pressure.
    out_ready = 1'b0;
    v = rand_wide();
    v[1140:571] = '0;
    send(v, v[570:0]);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", 571'(out_valid), 571'd1);
      check_eq("hold_in_ready", 571'(in_ready), 571'd0);
      check_eq("hold_r", r, v[570:0]);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("valid_fall", 571'(out_valid), 571'd0);
    check_eq("idle_in_ready", 571'(in_ready), 571'd1);
    wait_drain();

    // Reset during FOLD2 discards the operand.
    v = rand_wide();
    send(v, mod_f(v));
    @(posedge clk);
    #1;
    check_eq("in_fold2_busy", 571'(busy), 571'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    acc_q.delete();
    check_eq("arst_busy", 571'(busy), 571'd0);
    check_eq("arst_out_valid", 571'(out_valid), 571'd0);
    check_eq("arst_in_ready", 571'(in_ready), 571'd1);
    check_eq("arst_r", r, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("no_valid_after_rst", 571'(out_valid), 571'd0);
      @(posedge clk);
      #1;
    end
    v = '0;
    v[571] = 1'b1;
    send(v, 571'h425);
    wait_drain();

    // Back-to-back stream at full rate.
    stream_on = 1'b1;
    have_last = 1'b0;
    for (int i = 0; i < 100; i++) begin
      v = rand_wide();
      send(v, mod_f(v));
    end
    wait_drain();
    stream_on = 1'b0;

`ifdef GF571_RED_SQR_EN
    // Square of x^286 is x^572; upper half of c must be ignored.
    v = rand_wide();
    v[570:0] = '0;
    v[286] = 1'b1;
    e = '0;
    e[11] = 1'b1;
    e[6]  = 1'b1;
    e[3]  = 1'b1;
    e[1]  = 1'b1;
    sqr = 1'b1;
    send(v, e);
    sqr = 1'b0;
    wait_drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
